feature_map_deserializer: RTL

- Receive end of the feature stream interface. Takes a serial stream of 16-bit feature words, one channel per beat, and reassembles them into parallel vectors of FEATURE_DEPTH channels.
- Output shape matches the conv block's o_features / o_feature_valid bus, so it can feed a second conv layer or a pooling stage.
- Double-buffered: one group is collected while the previous group is held for downstream.
- Counts spatial positions and flags the end of each feature map.

---
 rtl/conv_pkg.sv | 15 +
 rtl/feature_map_deserializer_if.sv | 37 +++
 rtl/feature_group_reg.sv | 36 +++
 rtl/feature_map_deserializer.sv | 121 ++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and types for the conv feature-stream blocks.
package conv_pkg;

  localparam int unsigned FEATURE_WIDTH_DEFAULT = 16;
  localparam int unsigned FEATURE_DEPTH_DEFAULT = 6;
  localparam int unsigned MAP_SIZE_DEFAULT      = 784;

  typedef logic [FEATURE_WIDTH_DEFAULT-1:0] feature_t;

  typedef enum logic {
    COLLECT   = 1'b0,
    FULL_WAIT = 1'b1
  } deser_state_t;

endpackage

// File: rtl/feature_map_deserializer_if.sv
// Serial-in / parallel-out bus of the feature map deserializer.
// FEATURE_DESER_ALIGN_CHECK_EN adds the alignment-error status signals.
interface feature_map_deserializer_if
  import conv_pkg::*;
#(
  parameter int unsigned FEATURE_WIDTH = FEATURE_WIDTH_DEFAULT,
  parameter int unsigned FEATURE_DEPTH = FEATURE_DEPTH_DEFAULT
);
  logic                                         i_feature_valid;
  logic [FEATURE_WIDTH-1:0]                     i_feature;
  logic                                         i_sof;
  logic                                         o_feature_ready;
  logic                                         o_features_valid;
  logic [FEATURE_DEPTH-1:0][FEATURE_WIDTH-1:0]  o_features;
  logic                                         i_features_ready;
  logic                                         o_map_done;
`ifdef FEATURE_DESER_ALIGN_CHECK_EN
  logic                                         o_align_err;
  logic [7:0]                                   o_align_err_cnt;
`endif

  modport master (
    output i_feature_valid, i_feature, i_sof, i_features_ready,
    input  o_feature_ready, o_features_valid, o_features, o_map_done
`ifdef FEATURE_DESER_ALIGN_CHECK_EN
    , input o_align_err, o_align_err_cnt
`endif
  );

  modport slave (
    input  i_feature_valid, i_feature, i_sof, i_features_ready,
    output o_feature_ready, o_features_valid, o_features, o_map_done
`ifdef FEATURE_DESER_ALIGN_CHECK_EN
    , output o_align_err, o_align_err_cnt
`endif
  );
endinterface

// File: rtl/feature_group_reg.sv
// Output holding register: presents one parallel group until downstream takes it.
module feature_group_reg #(
  parameter int unsigned FEATURE_WIDTH = 16,
  parameter int unsigned FEATURE_DEPTH = 6
) (
  input  logic                                        i_clk,
  input  logic                                        i_rst_n,
  input  logic                                        i_load,
  input  logic [FEATURE_DEPTH-1:0][FEATURE_WIDTH-1:0] i_load_data,
  input  logic                                        i_ready,
  output logic                                        o_valid,
  output logic [FEATURE_DEPTH-1:0][FEATURE_WIDTH-1:0] o_data
);

  logic                                        valid_q;
  logic [FEATURE_DEPTH-1:0][FEATURE_WIDTH-1:0] data_q;

  // Data is only ever overwritten by a load, so it holds after draining.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      if (i_load) begin
        valid_q <= 1'b1;
        data_q  <= i_load_data;
      end else if (valid_q && i_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;

endmodule

// File: rtl/feature_map_deserializer.sv
// Reassembles serial feature words into FEATURE_DEPTH-wide groups, double-buffered.
// Optional FEATURE_DESER_ALIGN_CHECK_EN adds i_sof alignment error reporting.
module feature_map_deserializer
  import conv_pkg::*;
#(
  parameter int unsigned FEATURE_WIDTH = FEATURE_WIDTH_DEFAULT,
  parameter int unsigned FEATURE_DEPTH = FEATURE_DEPTH_DEFAULT,
  parameter int unsigned MAP_SIZE      = MAP_SIZE_DEFAULT
) (
  input logic                       i_clk,
  input logic                       i_rst_n,
  feature_map_deserializer_if.slave bus
);

  localparam int unsigned CW = (FEATURE_DEPTH > 1) ? $clog2(FEATURE_DEPTH) : 1;
  localparam int unsigned PW = (MAP_SIZE > 1) ? $clog2(MAP_SIZE) : 1;
  localparam logic [CW-1:0] LAST_CHAN = CW'(FEATURE_DEPTH - 1);
  localparam logic [PW-1:0] LAST_POS  = PW'(MAP_SIZE - 1);

  deser_state_t                                state_q, state_d;
  logic                                        ready_q;
  logic [CW-1:0]                               chan_q;
  logic [CW-1:0]                               wr_idx;
  logic [FEATURE_DEPTH-1:0][FEATURE_WIDTH-1:0] slot_q;
  logic [PW-1:0]                               pos_q;

  logic                                        in_xfer, out_xfer, last_word;
  logic                                        grp_load, grp_valid;
  logic [FEATURE_DEPTH-1:0][FEATURE_WIDTH-1:0] grp_data, grp_q;

  assign in_xfer   = bus.i_feature_valid && ready_q;
  assign out_xfer  = grp_valid && bus.i_features_ready;
  assign wr_idx    = bus.i_sof ? '0 : chan_q;
  assign last_word = in_xfer && (wr_idx == LAST_CHAN);

  always_comb begin
    state_d  = state_q;
    grp_load = 1'b0;
    grp_data = slot_q;
    case (state_q)
      COLLECT: begin
        // The last word bypasses the collect buffer straight into the output register.
        grp_data[FEATURE_DEPTH-1] = bus.i_feature;
        if (last_word) begin
          if (!grp_valid || out_xfer) grp_load = 1'b1;
          else                        state_d  = FULL_WAIT;
        end
      end
      FULL_WAIT: begin
        if (out_xfer) begin
          grp_load = 1'b1;
          state_d  = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // Ready drops with entry to FULL_WAIT but rises only one cycle after leaving it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= COLLECT;
      ready_q <= 1'b1;
      chan_q  <= '0;
      slot_q  <= '0;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == COLLECT) && (state_q == COLLECT);
      if (in_xfer) begin
        slot_q[wr_idx] <= bus.i_feature;
        chan_q         <= last_word ? '0 : wr_idx + 1'b1;
      end
      if (out_xfer) pos_q <= (pos_q == LAST_POS) ? '0 : pos_q + 1'b1;
    end
  end

  feature_group_reg #(
    .FEATURE_WIDTH (FEATURE_WIDTH),
    .FEATURE_DEPTH (FEATURE_DEPTH)
  ) u_group_reg (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_load      (grp_load),
    .i_load_data (grp_data),
    .i_ready     (bus.i_features_ready),
    .o_valid     (grp_valid),
    .o_data      (grp_q)
  );

  assign bus.o_feature_ready  = ready_q;
  assign bus.o_features_valid = grp_valid;
  assign bus.o_features       = grp_q;
  assign bus.o_map_done       = out_xfer && (pos_q == LAST_POS);

`ifdef FEATURE_DESER_ALIGN_CHECK_EN
  logic       sof_seen_q, align_err_q, align_hit;
  logic [7:0] align_cnt_q;

  assign align_hit = in_xfer &&
                     ((bus.i_sof && (chan_q != '0)) ||
                      (!bus.i_sof && (chan_q == '0) && sof_seen_q));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sof_seen_q  <= 1'b0;
      align_err_q <= 1'b0;
      align_cnt_q <= '0;
    end else begin
      if (in_xfer && bus.i_sof) sof_seen_q <= 1'b1;
      align_err_q <= align_hit;
      if (align_hit && (align_cnt_q != '1)) align_cnt_q <= align_cnt_q + 1'b1;
    end
  end

  assign bus.o_align_err     = align_err_q;
  assign bus.o_align_err_cnt = align_cnt_q;
`else
`endif

endmodule
